// File: rtl/gray_position_decoder.sv
// Synchronises an asynchronous Gray (or plain binary) position bus, decodes it,
// and turns each change into up/down steps, a wrapping position count and a sticky jump error.
//
//   state   | meaning
//   S_INIT  | reload reference value, no events (after reset, clear or mode switch)
//   S_TRACK | classify each change as +1, -1 or illegal jump
//   S_FAULT | illegal jump seen; output keeps tracking, counting frozen until clear
module gray_position_decoder #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   gray_in,
  input  logic               select,
  input  logic               clear,
  output logic [WIDTH-1:0]   binary_out,
  output logic               step_valid,
  output logic               dir,
  output logic [COUNT_W-1:0] pos_count,
  output logic               step_err
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  logic [WIDTH-1:0]       r_gray_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] r_sel_sync;
  state_t                 r_state;
  logic                   r_ss_prev;
  logic [WIDTH-1:0]       r_binary;
  logic                   r_step_valid;
  logic                   r_dir;
  logic [COUNT_W-1:0]     r_count;
  logic                   r_err;

  logic [WIDTH-1:0]   w_gs;
  logic               w_ss;
  logic [WIDTH-1:0]   w_gray_bin;
  logic [WIDTH-1:0]   w_d;
  logic [WIDTH-1:0]   w_delta;
  state_t             w_state_nxt;
  logic               w_valid_nxt;
  logic               w_dir_nxt;
  logic [COUNT_W-1:0] w_count_nxt;
  logic               w_err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_gray_sync[i] <= '0;
      r_sel_sync <= '0;
    end else begin
      r_gray_sync[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_gray_sync[i] <= r_gray_sync[i-1];
      r_sel_sync <= {r_sel_sync[SYNC_STAGES-2:0], select};
    end
  end

  assign w_gs = r_gray_sync[SYNC_STAGES-1];
  assign w_ss = r_sel_sync[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    w_gray_bin = '0;
    for (int i = 0; i < WIDTH; i++) w_gray_bin[i] = ^(w_gs >> i);
  end

  assign w_d     = w_ss ? w_gray_bin : w_gs;
  assign w_delta = w_d - r_binary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_INIT;
      r_ss_prev    <= 1'b0;
      r_binary     <= '0;
      r_step_valid <= 1'b0;
      r_dir        <= 1'b0;
      r_count      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ss_prev    <= w_ss;
      r_binary     <= w_d;
      r_step_valid <= w_valid_nxt;
      r_dir        <= w_dir_nxt;
      r_count      <= w_count_nxt;
      r_err        <= w_err_nxt;
    end
  end

  // Clear outranks a mode switch, which outranks normal step classification.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = 1'b0;
    w_dir_nxt   = r_dir;
    w_count_nxt = r_count;
    w_err_nxt   = r_err;
    if (clear) begin
      w_state_nxt = S_INIT;
      w_count_nxt = '0;
      w_err_nxt   = 1'b0;
    end else if (w_ss != r_ss_prev) begin
      w_state_nxt = S_INIT;
    end else begin
      case (r_state)
        S_INIT:  w_state_nxt = S_TRACK;
        S_TRACK: begin
          if (w_delta == WIDTH'(1)) begin
            w_valid_nxt = 1'b1;
            w_dir_nxt   = 1'b1;
            w_count_nxt = r_count + COUNT_W'(1);
          end else if (w_delta == {WIDTH{1'b1}}) begin
            w_valid_nxt = 1'b1;
            w_dir_nxt   = 1'b0;
            w_count_nxt = r_count - COUNT_W'(1);
          end else if (w_delta != '0) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_FAULT;
          end
        end
        S_FAULT: w_state_nxt = S_FAULT;
        default: w_state_nxt = S_INIT;
      endcase
    end
  end

  assign binary_out = r_binary;
  assign step_valid = r_step_valid;
  assign dir        = r_dir;
  assign pos_count  = r_count;
  assign step_err   = r_err;

endmodule

// File: tb/tb_gray_position_decoder.sv
// Scoreboard bench for gray_position_decoder: a small behavioural model pushes the
// expected output word for each bus change, popped once the decoder latency has elapsed.
module tb_gray_position_decoder;
  localparam int W  = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  gray_in = '0;
  logic          select = 1'b1;
  logic          clear = 1'b0;
  logic [W-1:0]  binary_out;
  logic          step_valid;
  logic          dir;
  logic [CW-1:0] pos_count;
  logic          step_err;

  int checks = 0;
  int failures = 0;

  // {binary_out, step_valid, dir, pos_count, step_err}
  logic [13:0] sb_q[$];
  logic [W-1:0]  m_prev;
  logic [CW-1:0] m_count;
  logic          m_dir, m_err, m_fault, m_sel;

  gray_position_decoder #(.WIDTH(W), .SYNC_STAGES(2), .COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .select(select), .clear(clear),
    .binary_out(binary_out), .step_valid(step_valid), .dir(dir),
    .pos_count(pos_count), .step_err(step_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] decode(input logic [W-1:0] g, input logic s);
    return s ? (g ^ (g >> 1) ^ (g >> 2)) : g;
  endfunction

  function automatic logic [13:0] obs();
    return {binary_out, step_valid, dir, pos_count, step_err};
  endfunction

  task automatic model_reset(input logic [W-1:0] g, input logic s);
    m_prev = decode(g, s); m_count = '0; m_dir = 1'b0;
    m_err = 1'b0; m_fault = 1'b0; m_sel = s;
  endtask

  task automatic do_reset(input logic [W-1:0] g, input logic s);
    @(negedge clk);
    rst_n = 1'b0; gray_in = g; select = s; clear = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset(g, s);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] g, input logic s);
    logic [W-1:0] d, delta;
    logic sv;
    @(negedge clk);
    gray_in = g; select = s;
    d = decode(g, s);
    delta = d - m_prev;
    sv = 1'b0;
    if (s !== m_sel) m_fault = 1'b0;
    else if (!m_fault) begin
      if (delta == 3'd1) begin sv = 1'b1; m_dir = 1'b1; m_count = m_count + 8'd1; end
      else if (delta == 3'd7) begin sv = 1'b1; m_dir = 1'b0; m_count = m_count - 8'd1; end
      else if (delta != 3'd0) begin m_err = 1'b1; m_fault = 1'b1; end
    end
    m_sel = s; m_prev = d;
    sb_q.push_back({d, sv, m_dir, m_count, m_err});
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    m_count = '0; m_err = 1'b0; m_fault = 1'b0;
    sb_q.push_back({m_prev, 1'b0, m_dir, m_count, 1'b0});
    @(posedge clk);
    #1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wait_lat();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] e;
    rst_n = 1'b0; gray_in = '0; select = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs() !== 14'h0) begin failures++; $display("FAIL reset_hold actual=%h required=0", obs()); end
    do_reset(3'b000, 1'b1);
    e = {m_prev, 1'b0, m_dir, m_count, m_err};
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL reset_release actual=%h required=%h", obs(), e); end
  endtask

  task automatic test_count_up();
    logic [W-1:0] codes[3] = '{3'b001, 3'b011, 3'b010};
    logic [13:0] e;
    do_reset(3'b000, 1'b1);
    foreach (codes[i]) begin
      drive(codes[i], 1'b1);
      wait_lat();
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL count_up[%0d] actual=%h required=%h", i, obs(), e); end
      @(posedge clk); #1;
      checks++;
      if (step_valid !== 1'b0) begin failures++; $display("FAIL count_up_pulse[%0d] actual=%b required=0", i, step_valid); end
    end
    checks++;
    if (pos_count !== 8'd3) begin failures++; $display("FAIL count_up_total actual=%h required=03", pos_count); end
  endtask

  task automatic test_count_down();
    logic [W-1:0] codes[4] = '{3'b100, 3'b101, 3'b111, 3'b110};
    logic [13:0] e;
    do_reset(3'b000, 1'b1);
    foreach (codes[i]) begin
      drive(codes[i], 1'b1);
      wait_lat();
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL count_down[%0d] actual=%h required=%h", i, obs(), e); end
      @(posedge clk); #1;
      checks++;
      if (step_valid !== 1'b0) begin failures++; $display("FAIL count_down_pulse[%0d] actual=%b required=0", i, step_valid); end
    end
    checks++;
    if (pos_count !== 8'hFC) begin failures++; $display("FAIL count_down_total actual=%h required=fc", pos_count); end
  endtask

  task automatic test_illegal_jump();
    logic [13:0] e;
    do_reset(3'b000, 1'b1);
    drive(3'b011, 1'b1);
    wait_lat();
    e = sb_q.pop_front();
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL jump_err actual=%h required=%h", obs(), e); end
    drive(3'b010, 1'b1);
    wait_lat();
    e = sb_q.pop_front();
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL jump_frozen actual=%h required=%h", obs(), e); end
    pulse_clear();
    e = sb_q.pop_front();
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL jump_clear actual=%h required=%h", obs(), e); end
    drive(3'b110, 1'b1);
    wait_lat();
    e = sb_q.pop_front();
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL jump_recover actual=%h required=%h", obs(), e); end
  endtask

  task automatic test_reset_nonzero();
    @(negedge clk);
    rst_n = 1'b0; gray_in = 3'b101; select = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset(3'b101, 1'b1);
    repeat (2) @(posedge clk); #1;
    checks++;
    if (binary_out !== 3'd0) begin failures++; $display("FAIL nz_latency actual=%0d required=0", binary_out); end
    @(posedge clk); #1;
    checks++;
    if (obs() !== {3'd6, 1'b0, 1'b0, 8'd0, 1'b0}) begin failures++; $display("FAIL nz_release actual=%h required=%h", obs(), {3'd6, 11'd0}); end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (obs() !== {3'd6, 11'd0}) begin failures++; $display("FAIL nz_settle actual=%h required=%h", obs(), {3'd6, 11'd0}); end
  endtask

  task automatic test_bypass();
    logic [13:0] e;
    do_reset(3'd3, 1'b0);
    pulse_clear();
    e = sb_q.pop_front();
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL bypass_clear actual=%h required=%h", obs(), e); end
    drive(3'd4, 1'b0);
    drive_check_hold: begin end
    wait_lat();
    e = sb_q.pop_front();
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL bypass_step actual=%h required=%h", obs(), e); end
    drive(3'd4, 1'b1);
    wait_lat();
    e = sb_q.pop_front();
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL bypass_mode_switch actual=%h required=%h", obs(), e); end
    repeat (2) @(posedge clk); #1;
    checks++;
    if (step_valid !== 1'b0 || step_err !== 1'b0) begin failures++; $display("FAIL bypass_quiet actual=%b%b required=00", step_valid, step_err); end
    drive(3'b000, 1'b1);
    wait_lat();
    e = sb_q.pop_front();
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL bypass_wrap_up actual=%h required=%h", obs(), e); end
  endtask

  task automatic test_count_wrap();
    logic [13:0] e;
    logic [W-1:0] b;
    do_reset(3'b000, 1'b1);
    for (int i = 1; i <= 130; i++) begin
      b = W'(i);
      drive(b ^ (b >> 1), 1'b1);
      wait_lat();
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL wrap_step[%0d] actual=%h required=%h", i, obs(), e); end
    end
    checks++;
    if (pos_count !== 8'h82) begin failures++; $display("FAIL wrap_total actual=%h required=82", pos_count); end
  endtask

  task automatic test_reset_mid();
    logic [13:0] e;
    logic [W-1:0] b;
    do_reset(3'b000, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      b = W'(i);
      drive(b ^ (b >> 1), 1'b1);
      wait_lat();
      void'(sb_q.pop_front());
    end
    drive(3'b000, 1'b1);
    wait_lat();
    e = sb_q.pop_front();
    checks++;
    if (obs() !== e || pos_count !== 8'd5 || step_err !== 1'b1) begin failures++; $display("FAIL mid_setup actual=%h required=%h", obs(), e); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 14'h0) begin failures++; $display("FAIL mid_reset_immediate actual=%h required=0", obs()); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset(3'b000, 1'b1);
    repeat (5) @(posedge clk); #1;
    checks++;
    if (obs() !== 14'h0) begin failures++; $display("FAIL mid_release actual=%h required=0", obs()); end
    drive(3'b001, 1'b1);
    wait_lat();
    e = sb_q.pop_front();
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL mid_resume actual=%h required=%h", obs(), e); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_illegal_jump();
    test_reset_nonzero();
    test_bypass();
    test_count_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
